// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared types and constants for the ALU issue/writeback sequencer.
// Optional feature macro: ALU_SEQ_IMM_EN (adds immediate fields to instr_t).
package alu_seq_pkg;

    localparam int DATA_W  = 16;
    localparam int IMM_W   = 8;
    // Register-index fields are sized for the largest supported file (16 entries).
    localparam int RAW_MAX = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    localparam logic [2:0] OP_NEG = 3'b000;
    localparam logic [2:0] OP_INC = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_ASH = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_CAT = 3'b110;
    localparam logic [2:0] OP_ILL = 3'b111;

    typedef struct packed {
        logic [2:0]         op;
        logic [RAW_MAX-1:0] dst;
        logic [RAW_MAX-1:0] srca;
        logic [RAW_MAX-1:0] srcb;
        logic               cin;
`ifdef ALU_SEQ_IMM_EN
        logic               use_imm;
        logic [IMM_W-1:0]   imm;
`endif
    } instr_t;

    // The only width extension this block performs: 8-bit immediate to data width.
    function automatic logic [DATA_W-1:0] sext_imm(input logic [IMM_W-1:0] imm);
        return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
    endfunction

endpackage

// File: rtl/alu_seq_regfile.sv
// alu_seq_regfile: NUM_REGS x DATA_W register file, two combinational read
// ports, one synchronous write port, asynchronous active-low reset to zero.
module alu_seq_regfile
    import alu_seq_pkg::*;
#(
    parameter int NUM_REGS = 4,
    parameter int REG_AW   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] ra_addr,
    output logic [DATA_W-1:0] ra_data,
    input  logic [REG_AW-1:0] rb_addr,
    output logic [DATA_W-1:0] rb_data,
    input  logic              we,
    input  logic [REG_AW-1:0] waddr,
    input  logic [DATA_W-1:0] wdata
);

    logic [NUM_REGS-1:0][DATA_W-1:0] mem;

    // Storage: cleared on reset, single write per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign ra_data = mem[ra_addr];
    assign rb_data = mem[rb_addr];

endmodule

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: non-overlapped IDLE/EXEC/WB sequencer in front of a
// combinational 16-bit ALU. One instruction per three cycles; host loads
// share the register-file write port and win over instruction accept.
// Optional feature macro: ALU_SEQ_IMM_EN (sign-extended 8-bit immediate as B).
module alu_seq_ctrl
    import alu_seq_pkg::*;
#(
    parameter int NUM_REGS = 4,
    parameter int REG_AW   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic [REG_AW-1:0] in_dst,
    input  logic [REG_AW-1:0] in_srca,
    input  logic [REG_AW-1:0] in_srcb,
    input  logic              in_cin,
    input  logic              in_use_imm,
    input  logic [IMM_W-1:0]  in_imm,
    input  logic              ld_en,
    input  logic [REG_AW-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic              alu_c,
    output logic [2:0]        alu_op,
    input  logic [DATA_W-1:0] alu_w,
    input  logic              alu_zero,
    input  logic              alu_neg,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_zero,
    output logic              out_neg,
    output logic              out_err
);

    state_t            state;
    instr_t            ir;
    logic              accept;
    logic              ld_wr;
    logic              wb_wr;
    logic              busy;
    logic              rf_we;
    logic [REG_AW-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [DATA_W-1:0] ra_data;
    logic [DATA_W-1:0] rb_data;
    logic [DATA_W-1:0] b_sel;

    assign in_ready = (state == IDLE) && !ld_en;
    assign accept   = in_valid && in_ready;
    assign ld_wr    = (state == IDLE) && ld_en;
    assign wb_wr    = (state == WB) && (ir.op != OP_ILL);
    assign busy     = (state != IDLE);

    // Sequencer: strictly IDLE -> EXEC -> WB -> IDLE; reset discards any in-flight op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) state <= EXEC;
                EXEC:    state <= WB;
                WB:      state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Instruction register: captured only on accept, stable through EXEC and WB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir <= '0;
        end else if (accept) begin
            ir.op   <= in_op;
            ir.dst  <= RAW_MAX'(in_dst);
            ir.srca <= RAW_MAX'(in_srca);
            ir.srcb <= RAW_MAX'(in_srcb);
            ir.cin  <= in_cin;
`ifdef ALU_SEQ_IMM_EN
            ir.use_imm <= in_use_imm;
            ir.imm     <= in_imm;
`endif
        end
    end

    // Result and flag registers: updated at the end of WB for legal opcodes only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data <= '0;
            out_zero <= 1'b0;
            out_neg  <= 1'b0;
        end else if (wb_wr) begin
            out_data <= alu_w;
            out_zero <= alu_zero;
            out_neg  <= alu_neg;
        end
    end

    // Single write port: WB and host load are mutually exclusive by state.
    always_comb begin
        rf_we    = ld_wr || wb_wr;
        rf_waddr = ld_addr;
        rf_wdata = ld_data;
        if (wb_wr) begin
            rf_waddr = ir.dst[REG_AW-1:0];
            rf_wdata = alu_w;
        end
    end

    alu_seq_regfile #(
        .NUM_REGS (NUM_REGS),
        .REG_AW   (REG_AW)
    ) u_rf (
        .clk     (clk),
        .rst_n   (rst_n),
        .ra_addr (ir.srca[REG_AW-1:0]),
        .ra_data (ra_data),
        .rb_addr (ir.srcb[REG_AW-1:0]),
        .rb_data (rb_data),
        .we      (rf_we),
        .waddr   (rf_waddr),
        .wdata   (rf_wdata)
    );

`ifdef ALU_SEQ_IMM_EN
    assign b_sel = ir.use_imm ? sext_imm(ir.imm) : rb_data;
`else
    assign b_sel = rb_data;
    logic unused_imm;
    assign unused_imm = ^{in_use_imm, in_imm};
`endif

    // Register indices wider than this file's address never carry information.
    generate
        if (REG_AW < RAW_MAX) begin : g_idx_pad
            logic unused_idx_hi;
            assign unused_idx_hi = ^{ir.dst[RAW_MAX-1:REG_AW],
                                     ir.srca[RAW_MAX-1:REG_AW],
                                     ir.srcb[RAW_MAX-1:REG_AW]};
        end
    endgenerate

    // ALU drive: operands stay valid through WB (rf is written only at WB's end), zero in IDLE.
    always_comb begin
        alu_a  = '0;
        alu_b  = '0;
        alu_c  = 1'b0;
        alu_op = 3'b000;
        if (busy) begin
            alu_a  = ra_data;
            alu_b  = b_sel;
            alu_c  = ir.cin;
            alu_op = ir.op;
        end
    end

    // Completion strobe: one cycle in WB, err marks the illegal opcode.
    always_comb begin
        out_valid = (state == WB);
        out_err   = (state == WB) && (ir.op == OP_ILL);
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl with a behavioural ALU model on the alu_* pins.
module tb_alu_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [1:0]  in_dst, in_srca, in_srcb;
    logic        in_cin;
    logic        in_use_imm;
    logic [7:0]  in_imm;
    logic        ld_en;
    logic [1:0]  ld_addr;
    logic [15:0] ld_data;
    logic [15:0] alu_a, alu_b, alu_w;
    logic        alu_c;
    logic [2:0]  alu_op;
    logic        alu_zero, alu_neg;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_zero, out_neg, out_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_seq_ctrl #(.NUM_REGS(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_dst(in_dst), .in_srca(in_srca), .in_srcb(in_srcb),
        .in_cin(in_cin), .in_use_imm(in_use_imm), .in_imm(in_imm),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c), .alu_op(alu_op),
        .alu_w(alu_w), .alu_zero(alu_zero), .alu_neg(alu_neg),
        .out_valid(out_valid), .out_data(out_data),
        .out_zero(out_zero), .out_neg(out_neg), .out_err(out_err)
    );

    // Behavioural ALU standing in for the real combinational unit.
    logic [15:0] sum;
    always_comb begin
        sum   = alu_a + alu_b;
        alu_w = 16'h0000;
        case (alu_op)
            3'b000: alu_w = 16'h0000 - alu_a;
            3'b001: alu_w = alu_a + 16'h0001;
            3'b010: alu_w = alu_a + alu_b + {15'b0, alu_c};
            3'b011: alu_w = $signed(sum) >>> 1;
            3'b100: alu_w = alu_a & alu_b;
            3'b101: alu_w = alu_a | alu_b;
            3'b110: alu_w = {alu_a[7:0], alu_b[7:0]};
            default: alu_w = 16'h0000;
        endcase
    end
    assign alu_zero = (alu_w == 16'h0000);
    assign alu_neg  = alu_w[15];

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ld(input logic [1:0] addr, input logic [15:0] data);
        ld_en   = 1'b1;
        ld_addr = addr;
        ld_data = data;
        #1;
        chk("ld_ready_low", {15'b0, in_ready}, 16'h0000);
        step();
        ld_en = 1'b0;
    endtask

    // Full three-cycle transaction with checks in EXEC, WB and the following IDLE cycle.
    task automatic issue(input string tag, input logic [2:0] op, input logic [1:0] dst,
                         input logic [1:0] sa, input logic [1:0] sb, input logic cin,
                         input logic ui, input logic [7:0] imm,
                         input logic [15:0] ea, input logic [15:0] eb, input logic eerr,
                         input logic [15:0] edata, input logic ez, input logic en);
        in_valid = 1'b1; in_op = op; in_dst = dst; in_srca = sa; in_srcb = sb;
        in_cin = cin; in_use_imm = ui; in_imm = imm;
        #1;
        chk({tag, "_ready"}, {15'b0, in_ready}, 16'h0001);
        step();
        in_valid = 1'b0;
        #1;
        chk({tag, "_exec_op"}, {13'b0, alu_op}, {13'b0, op});
        chk({tag, "_exec_a"}, alu_a, ea);
        chk({tag, "_exec_b"}, alu_b, eb);
        chk({tag, "_exec_c"}, {15'b0, alu_c}, {15'b0, cin});
        chk({tag, "_exec_vld"}, {14'b0, out_valid, in_ready}, 16'h0000);
        step();
        chk({tag, "_wb_vld_err"}, {14'b0, out_valid, out_err}, {14'b0, 1'b1, eerr});
        chk({tag, "_wb_hold_a"}, alu_a, ea);
        step();
        chk({tag, "_post_vld_rdy"}, {14'b0, out_valid, in_ready}, 16'h0001);
        chk({tag, "_data"}, out_data, edata);
        chk({tag, "_flags"}, {14'b0, out_zero, out_neg}, {14'b0, ez, en});
        chk({tag, "_idle_alu"}, alu_a | alu_b | {13'b0, alu_op}, 16'h0000);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_op = 3'b0; in_dst = 2'd0; in_srca = 2'd0;
        in_srcb = 2'd0; in_cin = 1'b0; in_use_imm = 1'b0; in_imm = 8'h00;
        ld_en = 1'b0; ld_addr = 2'd0; ld_data = 16'h0000;
        step();
        chk("rst_ready", {15'b0, in_ready}, 16'h0001);
        chk("rst_vld_err", {14'b0, out_valid, out_err}, 16'h0000);
        chk("rst_data", out_data, 16'h0000);
        chk("rst_flags", {14'b0, out_zero, out_neg}, 16'h0000);
        step();
        rst_n = 1'b1;
        step();

        // Register file cleared by reset: r0 | r1 = 0.
        issue("or_rst", 3'b101, 2'd2, 2'd0, 2'd1, 1'b0, 1'b0, 8'h00,
              16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0);

        ld(2'd0, 16'h0005);
        ld(2'd1, 16'h0003);
        issue("add", 3'b010, 2'd2, 2'd0, 2'd1, 1'b1, 1'b0, 8'h00,
              16'h0005, 16'h0003, 1'b0, 16'h0009, 1'b0, 1'b0);
        issue("neg", 3'b000, 2'd3, 2'd0, 2'd0, 1'b0, 1'b0, 8'h00,
              16'h0005, 16'h0005, 1'b0, 16'hFFFB, 1'b0, 1'b1);
        issue("and1", 3'b100, 2'd1, 2'd0, 2'd3, 1'b0, 1'b0, 8'h00,
              16'h0005, 16'hFFFB, 1'b0, 16'h0001, 1'b0, 1'b0);
        ld(2'd2, 16'h0004);
        issue("and0", 3'b100, 2'd2, 2'd2, 2'd3, 1'b0, 1'b0, 8'h00,
              16'h0004, 16'hFFFB, 1'b0, 16'h0000, 1'b1, 1'b0);
        // Illegal opcode: strobe with err, result and flags keep previous values.
        issue("ill", 3'b111, 2'd0, 2'd0, 2'd1, 1'b0, 1'b0, 8'h00,
              16'h0005, 16'h0001, 1'b1, 16'h0000, 1'b1, 1'b0);

        // Load and instruction offered together: load wins, instruction goes next cycle.
        in_valid = 1'b1; in_op = 3'b010; in_dst = 2'd3; in_srca = 2'd0; in_srcb = 2'd1;
        in_cin = 1'b0; in_use_imm = 1'b0;
        ld(2'd1, 16'h0003);
        chk("ld_col_state", {15'b0, out_valid}, 16'h0000);
        issue("add_after_ld", 3'b010, 2'd3, 2'd0, 2'd1, 1'b0, 1'b0, 8'h00,
              16'h0005, 16'h0003, 1'b0, 16'h0008, 1'b0, 1'b0);

`ifdef ALU_SEQ_IMM_EN
        issue("imm", 3'b010, 2'd2, 2'd0, 2'd1, 1'b0, 1'b1, 8'hFE,
              16'h0005, 16'hFFFE, 1'b0, 16'h0003, 1'b0, 1'b0);
`else
        issue("imm", 3'b010, 2'd2, 2'd0, 2'd1, 1'b0, 1'b1, 8'hFE,
              16'h0005, 16'h0003, 1'b0, 16'h0008, 1'b0, 1'b0);
`endif

        // Reset during EXEC: instruction dropped, no strobe, everything cleared.
        in_valid = 1'b1; in_op = 3'b010; in_dst = 2'd3; in_srca = 2'd0; in_srcb = 2'd1;
        in_cin = 1'b1; in_use_imm = 1'b0;
        step();
        in_valid = 1'b0;
        #1;
        chk("mid_exec_op", {13'b0, alu_op}, 16'h0002);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", {15'b0, in_ready}, 16'h0001);
        chk("mid_rst_vld", {14'b0, out_valid, out_err}, 16'h0000);
        chk("mid_rst_data", out_data, 16'h0000);
        chk("mid_rst_flags", {14'b0, out_zero, out_neg}, 16'h0000);
        chk("mid_rst_alu", alu_a | alu_b | {13'b0, alu_op}, 16'h0000);
        step();
        chk("mid_rst_novld", {15'b0, out_valid}, 16'h0000);
        rst_n = 1'b1;
        step();
        issue("post_rst_r01", 3'b101, 2'd0, 2'd0, 2'd1, 1'b0, 1'b0, 8'h00,
              16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0);
        issue("post_rst_r23", 3'b101, 2'd1, 2'd2, 2'd3, 1'b0, 1'b0, 8'h00,
              16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog timeout observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

Issue/writeback sequencer that sits directly upstream of the combinational 16-bit ALU. Accepts one instruction at a time over a valid/ready handshake and reads two operands from a small internal register file. It drives the ALU operand/opcode inputs, then captures the ALU result and its zero/negative flags back into the register file and flag register. It also exposes each completed result on a one-cycle output strobe.

## Interface
- NUM_REGS, 4, register-file depth (power of two, 2..16); REG_AW = $clog2(NUM_REGS)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  instruction offered
- in_ready  out  1  block can accept instruction
- in_op  in  3  ALU opcode (000 neg, 001 inc, 010 add+cin, 011 add-then-arith-shift, 100 and, 101 or, 110 byte-concat, 111 illegal)
- in_dst / in_srca / in_srcb  in  REG_AW each  destination / source A / source B register
- in_cin  in  1  carry-in for opcode 010
- in_use_imm  in  1  B operand from immediate (only with ALU_SEQ_IMM_EN)
- in_imm  in  8  immediate, sign-extended to 16
- ld_en  in  1  host register load
- ld_addr  in  REG_AW  load address
- ld_data  in  16  load data
- alu_a, alu_b  out  16  to ALU inpA/inpB
- alu_c  out  1  to ALU inpC
- alu_op  out  3  to ALU opcode
- alu_w  in  16  ALU result
- alu_zero, alu_neg  in  1  ALU flags
- out_valid  out  1  one-cycle result strobe
- out_data  out  16  last result
- out_zero, out_neg  out  1  flag register
- out_err  out  1  qualifies out_valid: illegal opcode

## Operation
- FSM states: IDLE, EXEC, WB. IDLE -> EXEC on accept (in_valid & in_ready); EXEC -> WB unconditionally; WB -> IDLE unconditionally.
- in_ready = (state == IDLE) & ~ld_en. Load has priority; instruction is not accepted in a cycle with ld_en.
- ld_en is honoured only in IDLE; ignored in EXEC/WB.
- On accept, latch op, dst, srca, srcb, cin, use_imm, imm into an instruction register.
- EXEC: alu_a = rf[srca]; alu_b = use_imm ? sext(imm) : rf[srcb]; alu_c = cin; alu_op = op.
- Operand and opcode outputs hold their values through WB. In IDLE they drive 0.
- WB, op != 111:
  - rf[dst] <= alu_w; out_data <= alu_w
  - out_zero <= alu_zero; out_neg <= alu_neg
  - out_valid = 1, out_err = 0
- WB, op == 111: no register write; out_data and flags unchanged; out_valid = 1, out_err = 1.
- All arithmetic is inside the ALU. This block does no width extension beyond the immediate sign-extend.
- Reads in EXEC see any write from the previous instruction's WB. Issue is non-overlapped, so there are no hazards.

## Timing
- Reset (async, any state): state = IDLE; all rf entries, out_data, out_zero, out_neg, and the instruction register = 0; out_valid = 0, out_err = 0; alu_* = 0; in_ready = 1.
- Accept at edge N: EXEC during cycle N+1, WB during N+2.
- out_valid is high for exactly the N+2 cycle. rf, out_data and flags are updated at the end of N+2.
- in_ready rises in cycle N+3. Throughput is one instruction per 3 cycles.
- ld_en in IDLE writes rf[ld_addr] at that edge; a same-cycle accept is refused.
- Reset mid-EXEC/WB: the instruction is discarded, no write occurs, and no out_valid is issued.

## Configuration
- ALU_SEQ_IMM_EN defined: in_use_imm selects sign-extended in_imm as the B operand.
- ALU_SEQ_IMM_EN undefined: in_use_imm and in_imm are ignored, the instruction register omits them, and B is always rf[srcb].

## Structure
- alu_seq_pkg holds:
  - state enum {IDLE, EXEC, WB}
  - opcode localparams (OP_NEG..OP_ILL)
  - instr_t packed struct (op, dst, srca, srcb, cin, use_imm, imm)
  - DATA_W = 16
- Sub-module alu_seq_regfile: NUM_REGS x 16, two combinational read ports, one synchronous write port, async reset. WB write is muxed against the ld write; the FSM guarantees they never collide.

## Test plan
- Reset asserted mid-stream -> in_ready = 1, out_valid = 0, out_data = 0x0000, flags 0, all registers read 0.
- Load r0 = 0x0005, r1 = 0x0003; issue add r2 = r0 + r1, cin = 1 -> alu_op = 010 in cycle N+1; out_valid in N+2 with out_data = 0x0009, zero = 0, neg = 0; in_ready high in N+3.
- Issue neg r3 = -r0 -> 0xFFFB, neg = 1. Then and r0 & r3 -> 0x0001. Then and r2 & r3 with r2 = 0x0004 -> 0x0000, zero = 1.
- Issue op 111 -> out_valid = 1, out_err = 1; r-file and flags unchanged.
- Assert ld_en together with in_valid in IDLE -> load written, in_ready = 0, instruction accepted the following cycle.
- With ALU_SEQ_IMM_EN: add r0 + imm 0xFE, cin = 0 -> alu_b = 0xFFFE, result 0x0003. Without the macro, the same stimulus uses rf[srcb].
